// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the RV32I data memory path.
// Holds the load/store size codes, byte-enable type and response payload.
package riscv_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned XLEN       = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef logic [WORD_BYTES-1:0] byte_en_t;

    typedef struct packed {
        logic            err;
        logic [XLEN-1:0] rdata;
    } mem_rsp_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: byte enables, write-data
// replication, alignment/size fault detection and load sign/zero extension.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic            we_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rword_i,
    output byte_en_t        be_c_o,
    output logic [XLEN-1:0] wdata_c_o,
    output logic            fault_c_o,
    output logic [XLEN-1:0] rdata_c_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Request path: unsigned sizes are load-only, so they fault for stores.
    always_comb begin
        be_c_o    = '0;
        wdata_c_o = wdata_i;
        fault_c_o = 1'b0;
        case (funct3_i)
            F3_B: begin
                be_c_o    = byte_en_t'(4'b0001 << addr_lo_i);
                wdata_c_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                be_c_o    = byte_en_t'(4'b0011 << {addr_lo_i[1], 1'b0});
                wdata_c_o = {2{wdata_i[15:0]}};
                fault_c_o = addr_lo_i[0];
            end
            F3_W: begin
                be_c_o    = 4'b1111;
                fault_c_o = (addr_lo_i != 2'd0);
            end
            F3_BU:   fault_c_o = we_i;
            F3_HU:   fault_c_o = we_i | addr_lo_i[0];
            default: fault_c_o = 1'b1;
        endcase
        if (fault_c_o) begin
            be_c_o = '0;
        end
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    lane_byte = rword_i[7:0];
            2'd1:    lane_byte = rword_i[15:8];
            2'd2:    lane_byte = rword_i[23:16];
            default: lane_byte = rword_i[31:24];
        endcase
        lane_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    always_comb begin
        rdata_c_o = '0;
        case (funct3_i)
            F3_B:    rdata_c_o = {{24{lane_byte[7]}}, lane_byte};
            F3_H:    rdata_c_o = {{16{lane_half[15]}}, lane_half};
            F3_W:    rdata_c_o = rword_i;
            F3_BU:   rdata_c_o = {24'd0, lane_byte};
            F3_HU:   rdata_c_o = {16'd0, lane_half};
            default: rdata_c_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Clocked RV32I data memory with valid/ready request/response handshake,
// byte-lane stores, extended loads and fault reporting.
module data_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned DEPTH        = 128,
    parameter int unsigned INIT_PATTERN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [XLEN-1:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = (INIT_PATTERN != 0) ? XLEN'(i) : '0;
        end
        return m;
    endfunction

    // Contents exist from time zero and are deliberately untouched by reset.
    mem_t mem_q = mem_init();

    logic [IDX_W-1:0]  word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic              range_err;
    logic              fault;
    logic              req_err;
    logic              accept;
    logic              wr_en;
    logic [XLEN-1:0]   raw_word;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   wr_data;
    byte_en_t          wr_be;

    logic              rsp_valid_q, rsp_valid_d;
    mem_rsp_t          rsp_q, rsp_d;

    assign word_idx  = req_addr[ADDR_WIDTH-1:2];
    assign mem_idx   = MEM_AW'(word_idx);
    assign range_err = (32'(word_idx) >= DEPTH);
    assign raw_word  = range_err ? '0 : mem_q[mem_idx];

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign req_err   = fault || range_err;
    assign wr_en     = accept && req_we && !req_err;

    mem_lane_align u_align (
        .we_i      (req_we),
        .funct3_i  (req_funct3),
        .addr_lo_i (req_addr[1:0]),
        .wdata_i   (req_wdata),
        .rword_i   (raw_word),
        .be_c_o    (wr_be),
        .wdata_c_o (wr_data),
        .fault_c_o (fault),
        .rdata_c_o (load_data)
    );

    // Stores commit on the accept edge so a following load sees them without bypass.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < int'(WORD_BYTES); b++) begin
                if (wr_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_d.err   = req_err;
            rsp_d.rdata = (req_err || req_we) ? '0 : load_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected responses are queued when a
// request is driven and compared when the response handshake completes.
module tb_data_mem_ctrl;

    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    data_mem_ctrl #(.ADDR_WIDTH(AW), .DEPTH(64), .INIT_PATTERN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.tag, "_rdata"}, rsp_rdata, mon_e.rdata);
                check({mon_e.tag, "_err"}, 32'(rsp_err), 32'(mon_e.err));
            end
        end
    end

    task automatic idle_req();
        req_valid  = 1'b0;
        req_we     = 1'bx;
        req_funct3 = 3'bx;
        req_addr   = 'x;
        req_wdata  = 'x;
    endtask

    task automatic send(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input string tag, input bit push = 1'b1);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.tag   = tag;
        if (push) exp_q.push_back(e);
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
            if (push) void'(exp_q.pop_back());
        end else begin
            @(posedge clk);
        end
        #1 idle_req();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        idle_req();
        #3;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic load, byte store and extensions.
        send(1'b0, 3'd2, 9'h010, 32'h0, 32'h0000_0004, 1'b0, "lw_010");
        send(1'b1, 3'd0, 9'h011, 32'h0000_00AB, 32'h0, 1'b0, "sb_011");
        send(1'b0, 3'd2, 9'h010, 32'h0, 32'h0000_AB04, 1'b0, "lw_010_after_sb");
        send(1'b0, 3'd0, 9'h011, 32'h0, 32'hFFFF_FFAB, 1'b0, "lb_011");
        send(1'b0, 3'd4, 9'h011, 32'h0, 32'h0000_00AB, 1'b0, "lbu_011");

        // Halfword store to upper half and extensions.
        send(1'b1, 3'd1, 9'h016, 32'h0000_8001, 32'h0, 1'b0, "sh_016");
        send(1'b0, 3'd1, 9'h016, 32'h0, 32'hFFFF_8001, 1'b0, "lh_016");
        send(1'b0, 3'd5, 9'h016, 32'h0, 32'h0000_8001, 1'b0, "lhu_016");
        send(1'b0, 3'd2, 9'h014, 32'h0, 32'h8001_0005, 1'b0, "lw_014");

        // Faults: misaligned, illegal size, out of range; none may write.
        send(1'b0, 3'd2, 9'h012, 32'h0, 32'h0, 1'b1, "lw_misalign");
        send(1'b1, 3'd1, 9'h021, 32'hFFFF_FFFF, 32'h0, 1'b1, "sh_misalign");
        send(1'b0, 3'd2, 9'h020, 32'h0, 32'h0000_0008, 1'b0, "lw_020_unchanged");
        send(1'b0, 3'd2, 9'h100, 32'h0, 32'h0, 1'b1, "lw_oor");
        send(1'b1, 3'd2, 9'h104, 32'h5555_5555, 32'h0, 1'b1, "sw_oor");
        send(1'b0, 3'd2, 9'h004, 32'h0, 32'h0000_0001, 1'b0, "lw_004_no_alias");
        send(1'b0, 3'd3, 9'h000, 32'h0, 32'h0, 1'b1, "ld_f3_3");
        send(1'b0, 3'd7, 9'h000, 32'h0, 32'h0, 1'b1, "ld_f3_7");
        send(1'b1, 3'd4, 9'h008, 32'h1234_5678, 32'h0, 1'b1, "st_f3_4");
        send(1'b0, 3'd1, 9'h013, 32'h0, 32'h0, 1'b1, "lh_misalign");
        send(1'b0, 3'd2, 9'h008, 32'h0, 32'h0000_0002, 1'b0, "lw_008_unchanged");

        // Read-after-write on consecutive cycles.
        send(1'b1, 3'd2, 9'h030, 32'h1234_5678, 32'h0, 1'b0, "sw_030");
        send(1'b0, 3'd2, 9'h030, 32'h0, 32'h1234_5678, 1'b0, "lw_030_raw");
        send(1'b0, 3'd0, 9'h033, 32'h0, 32'h0000_0012, 1'b0, "lb_033");
        drain();

        // Back-to-back loads complete on consecutive cycles.
        pop_cyc.delete();
        send(1'b0, 3'd2, 9'h000, 32'h0, 32'h0000_0000, 1'b0, "b2b_0");
        send(1'b0, 3'd2, 9'h004, 32'h0, 32'h0000_0001, 1'b0, "b2b_1");
        send(1'b0, 3'd2, 9'h008, 32'h0, 32'h0000_0002, 1'b0, "b2b_2");
        drain();
        check("b2b_count", 32'(pop_cyc.size()), 32'd3);
        if (pop_cyc.size() == 3) begin
            check("b2b_gap_01", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
            check("b2b_gap_12", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
        end

        // Backpressure: response held stable and requests blocked.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        send(1'b0, 3'd2, 9'h018, 32'h0, 32'h0000_0006, 1'b0, "hold_a");
        fork
            send(1'b0, 3'd2, 9'h01C, 32'h0, 32'h0000_0007, 1'b0, "hold_b");
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("hold_valid", 32'(rsp_valid), 32'd1);
                    check("hold_rdata", rsp_rdata, 32'h0000_0006);
                    check("hold_req_ready", 32'(req_ready), 32'd0);
                end
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        drain();

        // Async reset drops a pending response; memory survives.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        send(1'b1, 3'd2, 9'h00C, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw_00c", 1'b0);
        @(negedge clk);
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        send(1'b0, 3'd2, 9'h00C, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_00c_after_rst");
        drain();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
